servo_track_arbiter: RTL and testbench
======================================

// Module: servo_track_arbiter
// PURPOSE
//  Arbitrates the FPGA-camera and K210 target-coordinate streams for one pan/tilt servo pair.
//  Once per PWM period it runs a bounded proportional step to produce the x/y duty setpoints.
//  Recentres the servos after a long target loss. Sits between the coordinate sources and the
//  PWM generator; duty values are in clk cycles, 100 MHz (10 ns).
// PARAMETERS
//  PERIOD_CYC   2_000_000  clk cycles per servo period (20 ms)
//  DUTY_MIN     50_000     lower duty clamp (0.5 ms)
//  DUTY_MAX     250_000    upper duty clamp (2.5 ms)
//  DUTY_CTR     150_000    centre / reset duty (1.5 ms)
//  CTR_X        400        target x pixel
//  CTR_Y        240        target y pixel
//  DEADBAND     8          |err| <= DEADBAND gives no step
//  KP           3          duty cycles per pixel of error
//  MAX_STEP     1_500      max |duty change| per period while tracking
//  LOST_PERIODS 250        periods without any sample before homing (5 s)
//  HOME_STEP    1_000      duty change per period while homing
// PORTS
//  clk         in   1   system clock, 100 MHz
//  rst_n       in   1   async active-low reset
//  cam_x       in   10  FPGA-camera target x
//  cam_y       in   10  FPGA-camera target y
//  cam_valid   in   1   camera coordinate valid, level; rising edge = new sample
//  k210_x      in   10  K210 target x
//  k210_y      in   10  K210 target y
//  k210_valid  in   1   K210 coordinate valid, level; rising edge = new sample
//  k210_prio   in   1   1: K210 wins when both pending; 0: camera wins
//  x_duty      out  18  pan duty setpoint for the PWM generator
//  y_duty      out  18  tilt duty setpoint for the PWM generator
//  duty_upd    out  1   1-cycle pulse when x_duty/y_duty are written
//  period_tick out  1   1-cycle pulse when the period counter wraps
//  src_sel     out  2   0 none, 1 camera, 2 K210: source of the last applied sample
//  state       out  2   0 IDLE, 1 TRACK, 2 HOLD, 3 HOME
// BEHAVIOUR
//  Reset (async, any time): duty=DUTY_CTR on both axes; duty_upd=0; period_tick=0; src_sel=0;
//   state=IDLE; period counter=0; pending flags cleared; lost counter=0.
//  Period counter: counts 0..PERIOD_CYC-1. period_tick=1 in the cycle the counter holds PERIOD_CYC-1.
//  Capture: each valid input has a 2-FF synchroniser and a rising-edge detect. An edge latches
//   that source's x/y into its pending register and sets its pending flag. A later edge before
//   the tick overwrites the register (latest wins).
//  Tick processing: the tick cycle consumes and clears both pending flags.
//   An edge detected in the tick cycle itself sets pending for the next period.
//  Source choice at the tick:
//   - both pending: k210_prio chooses;
//   - one pending: that source;
//   - none: no sample.
//  FSM (transitions only on period_tick; next values are registered):
//   IDLE  sample -> TRACK; else stay.
//   TRACK sample -> TRACK (apply step); none -> HOLD, lost counter=1.
//   HOLD  sample -> TRACK, lost counter=0; none -> lost counter+1;
//         when the counter reaches LOST_PERIODS -> HOME.
//   HOME  sample -> TRACK (abort homing); else each axis moves HOME_STEP toward DUTY_CTR,
//         no overshoot; both axes at DUTY_CTR -> IDLE with src_sel=0.
//  Step arithmetic, per axis, in TRACK:
//   - err = pos - CTR as 11-bit signed;
//   - |err| <= DEADBAND gives step 0, else step = err*KP;
//   - clamp step to +/-MAX_STEP;
//   - new = duty - step, computed in 20-bit signed;
//   - clamp new to [DUTY_MIN, DUTY_MAX]; the clamp saturates, it never wraps.
//  Latency: x_duty, y_duty, src_sel and state update in the cycle after period_tick.
//   duty_upd pulses in that same cycle, only when the state is TRACK or HOME.
//  Duties hold constant between updates (glitch-free for PWM compare).
// TESTING
//  1 Reset, no samples, run 3 periods -> duty 150000/150000, state IDLE, duty_upd never 1.
//  2 cam edge x=500,y=240 -> next update: x_duty=149700, y_duty=150000 (deadband), src_sel=1, TRACK.
//  3 cam x=1000 -> step clamped, x_duty 150000->148500; repeat until 50000 -> holds at 50000, no wrap.
//  4 cam (500,240) and k210 (300,240) edges in the same period:
//    prio=1 -> x_duty +300, src_sel=2; prio=0 -> x_duty -300, src_sel=1.
//  5 From x_duty=140000, no samples: HOLD for 250 periods, then HOME.
//    10 updates of +1000 reach 150000, then IDLE. A cam edge mid-HOME -> TRACK at next tick.
//  6 Edge on the tick cycle -> applied one period later; rst_n low mid-HOME -> immediate centre/IDLE.

Source files
------------

// File: rtl/servo_track_arbiter.sv
// Pan/tilt servo setpoint arbiter: picks the camera or K210 target once per PWM period and moves
// the duties by a bounded proportional step, recentring after a long loss of target.
module servo_track_arbiter #(
  parameter int unsigned PERIOD_CYC   = 2_000_000,
  parameter int unsigned DUTY_MIN     = 50_000,
  parameter int unsigned DUTY_MAX     = 250_000,
  parameter int unsigned DUTY_CTR     = 150_000,
  parameter int unsigned CTR_X        = 400,
  parameter int unsigned CTR_Y        = 240,
  parameter int unsigned DEADBAND     = 8,
  parameter int unsigned KP           = 3,
  parameter int unsigned MAX_STEP     = 1_500,
  parameter int unsigned LOST_PERIODS = 250,
  parameter int unsigned HOME_STEP    = 1_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  cam_x_i,
  input  logic [9:0]  cam_y_i,
  input  logic        cam_valid_i,
  input  logic [9:0]  k210_x_i,
  input  logic [9:0]  k210_y_i,
  input  logic        k210_valid_i,
  input  logic        k210_prio_i,
  output logic [17:0] x_duty_o,
  output logic [17:0] y_duty_o,
  output logic        duty_upd_o,
  output logic        period_tick_o,
  output logic [1:0]  src_sel_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StTrack = 2'd1,
    StHold  = 2'd2,
    StHome  = 2'd3
  } state_e;

  localparam int unsigned CntW  = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int unsigned LostW = $clog2(LOST_PERIODS + 1);

  localparam logic [CntW-1:0]    CntLast  = CntW'(PERIOD_CYC - 1);
  localparam logic [LostW-1:0]   LostLast = LostW'(LOST_PERIODS - 1);
  localparam logic [17:0]        DutyCtr  = 18'(DUTY_CTR);
  localparam logic [17:0]        HomeStep = 18'(HOME_STEP);
  localparam logic signed [19:0] DutyMinS = 20'(DUTY_MIN);
  localparam logic signed [19:0] DutyMaxS = 20'(DUTY_MAX);
  localparam logic signed [19:0] MaxStepS = 20'(MAX_STEP);
  localparam logic signed [19:0] KpS      = 20'(KP);
  localparam logic [10:0]        DeadBand = 11'(DEADBAND);
  localparam logic [9:0]         CtrX     = 10'(CTR_X);
  localparam logic [9:0]         CtrY     = 10'(CTR_Y);
  localparam logic [1:0]         SrcNone  = 2'd0;
  localparam logic [1:0]         SrcCam   = 2'd1;
  localparam logic [1:0]         SrcK210  = 2'd2;

  // Bounded proportional move of one axis towards the target pixel.
  function automatic logic [17:0] track_step(input logic [17:0] duty, input logic [9:0] pos,
                                             input logic [9:0] ctr);
    logic signed [10:0] err;
    logic [10:0]        mag;
    logic signed [19:0] step;
    logic signed [19:0] nxt;
    err = $signed({1'b0, pos}) - $signed({1'b0, ctr});
    mag = err[10] ? 11'(-err) : 11'(err);
    if (mag <= DeadBand) begin
      step = '0;
    end else begin
      step = $signed({{9{err[10]}}, err}) * KpS;
    end
    if (step > MaxStepS) begin
      step = MaxStepS;
    end else if (step < -MaxStepS) begin
      step = -MaxStepS;
    end
    nxt = $signed({2'b00, duty}) - step;
    if (nxt < DutyMinS) begin
      nxt = DutyMinS;
    end else if (nxt > DutyMaxS) begin
      nxt = DutyMaxS;
    end
    return nxt[17:0];
  endfunction

  function automatic logic [17:0] home_step(input logic [17:0] duty);
    if (duty < DutyCtr) begin
      return ((DutyCtr - duty) > HomeStep) ? duty + HomeStep : DutyCtr;
    end
    return ((duty - DutyCtr) > HomeStep) ? duty - HomeStep : DutyCtr;
  endfunction

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             tick;
  logic [2:0]       cam_sync_q, k210_sync_q;
  logic             cam_edge, k210_edge;
  logic             cam_pend_q, cam_pend_d, k210_pend_q, k210_pend_d;
  logic [9:0]       cam_px_q, cam_px_d, cam_py_q, cam_py_d;
  logic [9:0]       k210_px_q, k210_px_d, k210_py_q, k210_py_d;
  state_e           state_q, state_d;
  logic [LostW-1:0] lost_q, lost_d;
  logic [17:0]      x_q, x_d, y_q, y_d;
  logic [1:0]       src_q, src_d;
  logic             upd_q, upd_d;
  logic             have_smp;
  logic [9:0]       smp_x, smp_y;
  logic [1:0]       smp_src;

  assign tick      = (cnt_q == CntLast);
  assign cnt_d     = tick ? '0 : cnt_q + CntW'(1);
  // Bits [1:0] are the synchroniser; bit 2 is the history for edge detection.
  assign cam_edge  = cam_sync_q[1] & ~cam_sync_q[2];
  assign k210_edge = k210_sync_q[1] & ~k210_sync_q[2];

  // An edge in the tick cycle wins over the tick's clear, so it lands in the next period.
  always_comb begin
    cam_pend_d  = cam_edge | (cam_pend_q & ~tick);
    k210_pend_d = k210_edge | (k210_pend_q & ~tick);
    cam_px_d    = cam_edge ? cam_x_i : cam_px_q;
    cam_py_d    = cam_edge ? cam_y_i : cam_py_q;
    k210_px_d   = k210_edge ? k210_x_i : k210_px_q;
    k210_py_d   = k210_edge ? k210_y_i : k210_py_q;
  end

  always_comb begin
    have_smp = 1'b0;
    smp_x    = '0;
    smp_y    = '0;
    smp_src  = SrcNone;
    if (cam_pend_q && (!k210_pend_q || !k210_prio_i)) begin
      have_smp = 1'b1;
      smp_x    = cam_px_q;
      smp_y    = cam_py_q;
      smp_src  = SrcCam;
    end else if (k210_pend_q) begin
      have_smp = 1'b1;
      smp_x    = k210_px_q;
      smp_y    = k210_py_q;
      smp_src  = SrcK210;
    end
  end

  always_comb begin
    state_d = state_q;
    lost_d  = lost_q;
    x_d     = x_q;
    y_d     = y_q;
    src_d   = src_q;
    upd_d   = 1'b0;
    if (tick) begin
      if (have_smp) begin
        state_d = StTrack;
        lost_d  = '0;
        x_d     = track_step(x_q, smp_x, CtrX);
        y_d     = track_step(y_q, smp_y, CtrY);
        src_d   = smp_src;
      end else begin
        unique case (state_q)
          StIdle: ;
          StTrack: begin
            state_d = StHold;
            lost_d  = LostW'(1);
          end
          StHold: begin
            lost_d = lost_q + LostW'(1);
            if (lost_q >= LostLast) begin
              state_d = StHome;
            end
          end
          StHome: begin
            if (x_q == DutyCtr && y_q == DutyCtr) begin
              state_d = StIdle;
              src_d   = SrcNone;
            end else begin
              x_d = home_step(x_q);
              y_d = home_step(y_q);
            end
          end
          default: ;
        endcase
      end
      upd_d = (state_d == StTrack) || (state_d == StHome);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cam_sync_q  <= '0;
      k210_sync_q <= '0;
      cam_pend_q  <= 1'b0;
      k210_pend_q <= 1'b0;
      cam_px_q    <= '0;
      cam_py_q    <= '0;
      k210_px_q   <= '0;
      k210_py_q   <= '0;
      state_q     <= StIdle;
      lost_q      <= '0;
      x_q         <= DutyCtr;
      y_q         <= DutyCtr;
      src_q       <= SrcNone;
      upd_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cam_sync_q  <= {cam_sync_q[1:0], cam_valid_i};
      k210_sync_q <= {k210_sync_q[1:0], k210_valid_i};
      cam_pend_q  <= cam_pend_d;
      k210_pend_q <= k210_pend_d;
      cam_px_q    <= cam_px_d;
      cam_py_q    <= cam_py_d;
      k210_px_q   <= k210_px_d;
      k210_py_q   <= k210_py_d;
      state_q     <= state_d;
      lost_q      <= lost_d;
      x_q         <= x_d;
      y_q         <= y_d;
      src_q       <= src_d;
      upd_q       <= upd_d;
    end
  end

  assign x_duty_o      = x_q;
  assign y_duty_o      = y_q;
  assign duty_upd_o    = upd_q;
  assign period_tick_o = tick;
  assign src_sel_o     = src_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_servo_track_arbiter.sv
// Bench for servo_track_arbiter: directed scenarios plus random periods, all checked against a
// per-period behavioural model of the tracking rules.
module tb_servo_track_arbiter;

  localparam int PER  = 40;
  localparam int LOST = 250;
  localparam int CTR  = 150000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  cam_x, cam_y, k210_x, k210_y;
  logic        cam_valid, k210_valid, k210_prio;
  logic [17:0] x_duty, y_duty;
  logic        duty_upd, period_tick;
  logic [1:0]  src_sel, state;

  always #5 clk = ~clk;

  servo_track_arbiter #(
    .PERIOD_CYC(PER)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cam_x_i      (cam_x),
    .cam_y_i      (cam_y),
    .cam_valid_i  (cam_valid),
    .k210_x_i     (k210_x),
    .k210_y_i     (k210_y),
    .k210_valid_i (k210_valid),
    .k210_prio_i  (k210_prio),
    .x_duty_o     (x_duty),
    .y_duty_o     (y_duty),
    .duty_upd_o   (duty_upd),
    .period_tick_o(period_tick),
    .src_sel_o    (src_sel),
    .state_o      (state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 track, 2 hold, 3 home.
  int m_state, m_x, m_y, m_src, m_lost;
  bit exp_upd;
  bit pc, pk;
  int pcx, pcy, pkx, pky;

  int stray_upd, since_tick;
  bit gap_valid, tick_seen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int track_m(input int duty, input int pos, input int ctr);
    int err, s, n;
    err = pos - ctr;
    s = (err >= -8 && err <= 8) ? 0 : err * 3;
    if (s > 1500) s = 1500;
    if (s < -1500) s = -1500;
    n = duty - s;
    if (n < 50000) n = 50000;
    if (n > 250000) n = 250000;
    return n;
  endfunction

  function automatic int home_m(input int duty);
    if (duty < CTR) return (duty + 1000 > CTR) ? CTR : duty + 1000;
    return (duty - 1000 < CTR) ? CTR : duty - 1000;
  endfunction

  function automatic int rand_coord(input int ctr);
    if ($urandom_range(0, 3) == 0) return ctr - 10 + int'($urandom_range(0, 20));
    return int'($urandom_range(0, 1023));
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = CTR; m_y = CTR; m_src = 0; m_lost = 0;
    pc = 0; pk = 0; exp_upd = 0;
  endtask

  task automatic model_tick();
    bit have;
    int sx, sy, ss;
    have = 0; sx = 0; sy = 0; ss = 0;
    if (pc && (!pk || !k210_prio)) begin
      have = 1; sx = pcx; sy = pcy; ss = 1;
    end else if (pk) begin
      have = 1; sx = pkx; sy = pky; ss = 2;
    end
    pc = 0; pk = 0;
    if (have) begin
      m_x = track_m(m_x, sx, 400);
      m_y = track_m(m_y, sy, 240);
      m_src = ss; m_state = 1; m_lost = 0;
    end else if (m_state == 1) begin
      m_state = 2; m_lost = 1;
    end else if (m_state == 2) begin
      m_lost++;
      if (m_lost >= LOST) m_state = 3;
    end else if (m_state == 3) begin
      if (m_x == CTR && m_y == CTR) begin
        m_state = 0; m_src = 0;
      end else begin
        m_x = home_m(m_x); m_y = home_m(m_y);
      end
    end
    exp_upd = (m_state == 1) || (m_state == 3);
  endtask

  task automatic step_cyc();
    @(negedge clk);
    since_tick++;
    if (duty_upd) stray_upd++;
    if (period_tick) begin
      if (gap_valid) check_val("tick_gap", since_tick, PER);
      since_tick = 0; gap_valid = 1; tick_seen = 1;
    end
  endtask

  task automatic pulse(input bit is_k, input int x, input int y);
    if (is_k) begin
      k210_x = 10'(x); k210_y = 10'(y); k210_valid = 1'b1;
    end else begin
      cam_x = 10'(x); cam_y = 10'(y); cam_valid = 1'b1;
    end
    repeat (3) step_cyc();
    cam_valid = 1'b0; k210_valid = 1'b0;
    repeat (3) step_cyc();
  endtask

  task automatic finish_period();
    for (int i = 0; i < PER + 4 && !tick_seen; i++) step_cyc();
    if (!tick_seen) check_val("tick_timeout", 0, 1);
    check_val("stray_upd", stray_upd, 0);
    model_tick();
    step_cyc();
    check_val("duty_upd", duty_upd, exp_upd);
    stray_upd = 0;
    tick_seen = 0;
    check_val("x_duty", x_duty, m_x);
    check_val("y_duty", y_duty, m_y);
    check_val("src_sel", src_sel, m_src);
    check_val("state", state, m_state);
  endtask

  task automatic do_period(input int cam_n, input int cx, input int cy, input bit k_en,
                           input int kx, input int ky, input bit prio);
    k210_prio = prio;
    for (int i = 0; i < cam_n; i++) begin
      if (i == cam_n - 1) pulse(1'b0, cx, cy);
      else pulse(1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    end
    if (cam_n > 0) begin pc = 1; pcx = cx; pcy = cy; end
    if (k_en) begin
      pulse(1'b1, kx, ky);
      pk = 1; pkx = kx; pky = ky;
    end
    finish_period();
  endtask

  task automatic check_reset_outputs();
    check_val("rst_x", x_duty, CTR);
    check_val("rst_y", y_duty, CTR);
    check_val("rst_state", state, 0);
    check_val("rst_src", src_sel, 0);
    check_val("rst_upd", duty_upd, 0);
    check_val("rst_tick", period_tick, 0);
  endtask

  task automatic apply_reset(input bit check_now);
    rst_n = 1'b0;
    #1;
    if (check_now) check_reset_outputs();
    repeat (2) step_cyc();
    rst_n = 1'b1;
    model_reset();
    gap_valid = 0; tick_seen = 0; stray_upd = 0;
  endtask

  task automatic idle_until_home(input int extra);
    for (int i = 0; i < LOST + 10 && m_state != 3; i++) do_period(0, 0, 0, 0, 0, 0, 0);
    check_val("reached_home", m_state, 3);
    for (int i = 0; i < extra; i++) do_period(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cam_x = '0; cam_y = '0; cam_valid = 1'b0;
    k210_x = '0; k210_y = '0; k210_valid = 1'b0; k210_prio = 1'b0;
    stray_upd = 0; since_tick = 0; gap_valid = 0; tick_seen = 0;
    model_reset();
    repeat (3) step_cyc();
    check_reset_outputs();
    rst_n = 1'b1;

    // Idle periods: nothing moves, no update pulses.
    repeat (3) do_period(0, 0, 0, 0, 0, 0, 0);
    // First sample: x steps by 300, y inside deadband.
    do_period(1, 500, 240, 0, 0, 0, 0);
    // Saturating steps drive x to the lower clamp and y to the upper clamp.
    repeat (145) do_period(1, 1000, 0, 0, 0, 0, 0);
    // Both sources pending: priority selects.
    do_period(1, 500, 240, 1, 300, 240, 1);
    do_period(1, 500, 240, 1, 300, 240, 0);
    // Latest-wins with two camera edges in one period.
    do_period(2, 420, 260, 0, 0, 0, 0);

    // Loss of target: hold, home without overshoot, then idle.
    apply_reset(1'b0);
    repeat (6) do_period(1, 1000, 100, 0, 0, 0, 0);
    for (int i = 0; i < LOST + 30 && m_state != 0; i++) do_period(0, 0, 0, 0, 0, 0, 0);
    check_val("home_done", m_state, 0);

    // A sample while homing aborts it.
    repeat (6) do_period(1, 1000, 100, 0, 0, 0, 0);
    idle_until_home(3);
    do_period(1, 400, 240, 0, 0, 0, 0);

    // Edge landing in the tick cycle is deferred one period.
    do_period(0, 0, 0, 0, 0, 0, 0);
    repeat (PER - 3) step_cyc();
    cam_x = 10'd500; cam_y = 10'd240; cam_valid = 1'b1;
    finish_period();
    pc = 1; pcx = 500; pcy = 240;
    repeat (3) step_cyc();
    cam_valid = 1'b0;
    finish_period();

    // Asynchronous reset in the middle of homing.
    do_period(1, 1000, 100, 0, 0, 0, 0);
    idle_until_home(2);
    repeat (10) step_cyc();
    apply_reset(1'b1);
    repeat (2) do_period(0, 0, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      int cn, kx, ky;
      bit ke;
      if ($urandom_range(0, 5) == 0) begin
        cn = 0; ke = 0;
      end else begin
        cn = int'($urandom_range(0, 2));
        ke = 1'($urandom_range(0, 1));
      end
      kx = rand_coord(400);
      ky = rand_coord(240);
      do_period(cn, rand_coord(400), rand_coord(240), ke, kx, ky, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
